// File: rtl/sram_pkg.sv
// Shared widths, write-FIFO entry layout and arbiter state encoding for the SRAM arbiter slice.
// No logic of its own; imported by the interface, FIFO and arbiter.
// Level width covers FIFO depths up to 7 entries with the default 3-bit occupancy port.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WR_LEVEL_W  = 3;

    // One buffered write: address in the upper bits, data in the lower 16 (34 bits total).
    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
    } wr_entry_t;

    // Arbiter states. ISSUE_x is the single strobe cycle, WAIT_x covers the controller busy time.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_RD = 3'd1,
        ST_ISSUE_WR = 3'd2,
        ST_WAIT_RD  = 3'd3,
        ST_WAIT_WR  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundles the read port, buffered write port and SRAM controller signals of the arbiter.
// No latency; pure wiring.
// slave = arbiter view; master = surrounding logic (requesters plus SRAM controller).
interface sram_arbiter_if;
    import sram_pkg::*;

    // Framebuffer read port
    logic                   rd_req;
    logic [SRAM_ADDR_W-1:0] rd_addr;
    logic                   rd_ack;
    logic [SRAM_DATA_W-1:0] rd_data;
    logic                   rd_valid;

    // Pen/pixel write port
    logic                   wr_valid;
    logic [SRAM_ADDR_W-1:0] wr_addr;
    logic [SRAM_DATA_W-1:0] wr_data;
    logic                   wr_ready;
    logic [WR_LEVEL_W-1:0]  wr_level;

    // SRAM controller side
    logic                   sram_write;
    logic                   sram_read;
    logic [SRAM_ADDR_W-1:0] sram_address;
    logic [SRAM_DATA_W-1:0] sram_data_write;
    logic [SRAM_DATA_W-1:0] sram_data_read;
    logic                   sram_ready;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, sram_data_read, sram_ready,
        output rd_ack, rd_data, rd_valid, wr_ready, wr_level,
               sram_write, sram_read, sram_address, sram_data_write
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, sram_data_read, sram_ready,
        input  rd_ack, rd_data, rd_valid, wr_ready, wr_level,
               sram_write, sram_read, sram_address, sram_data_write
    );

endinterface

// File: rtl/sram_wr_fifo.sv
// Synchronous FIFO buffering pending SRAM writes (address + data).
// Latency: a push is visible at the head one cycle later; dout is the current head, combinational.
// Backpressure: full blocks further pushes (dropped if attempted); pop on empty is ignored.
module sram_wr_fifo
    import sram_pkg::*;
#(
    parameter int DEPTH = 4,          // power of 2, at least 2, at most 2**LVL_W - 1
    parameter int LVL_W = WR_LEVEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  wr_entry_t        din,
    output wr_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    wr_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    // Both qualifiers use pre-cycle occupancy, so a fresh push into an empty FIFO
    // cannot be popped in the same cycle and a push/pop pair at full is not allowed to push.
    assign full      = (r_count == LVL_FULL);
    assign empty     = (r_count == '0);
    assign level     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between a latency-critical read port and a FIFO-buffered write port.
// Latency: read ack in the grant cycle T, strobe at T+1, rd_valid at T+5; one SRAM op in flight.
// Backpressure: rd_req is held until rd_ack; writes stall on wr_ready=0 when the FIFO is full.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int WR_FIFO_DEPTH = 4,
    parameter int MAX_RD_STREAK = 8
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);

    localparam int                  STREAK_W   = $clog2(MAX_RD_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

    arb_state_t             r_state;
    logic                   r_settle;
    logic                   r_sram_read;
    logic                   r_sram_write;
    logic [SRAM_ADDR_W-1:0] r_sram_address;
    logic [SRAM_DATA_W-1:0] r_sram_data_write;
    logic [SRAM_DATA_W-1:0] r_rd_data;
    logic                   r_rd_valid;
    logic [STREAK_W-1:0]    r_streak;

    wr_entry_t              w_fifo_din;
    wr_entry_t              w_fifo_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [WR_LEVEL_W-1:0]  w_fifo_level;
    logic                   w_idle_go;
    logic                   w_force_wr;
    logic                   w_grant_rd;
    logic                   w_grant_wr;

    assign w_fifo_din = '{addr: bus.wr_addr, data: bus.wr_data};

    sram_wr_fifo #(
        .DEPTH (WR_FIFO_DEPTH),
        .LVL_W (WR_LEVEL_W)
    ) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.wr_valid),
        .pop   (w_grant_wr),
        .din   (w_fifo_din),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_fifo_level)
    );

    // Grant decision, made only from IDLE with the controller idle. A full streak with a
    // write pending overrides reads; otherwise reads win and writes take the idle slots.
    assign w_idle_go  = !reset && (r_state == ST_IDLE) && bus.sram_ready;
    assign w_force_wr = !w_fifo_empty && (r_streak == STREAK_MAX);
    assign w_grant_rd = w_idle_go && bus.rd_req && !w_force_wr;
    assign w_grant_wr = w_idle_go && !w_fifo_empty && (w_force_wr || !bus.rd_req);

    // rd_ack is the grant itself so the requester sees acceptance in the grant cycle.
    assign bus.rd_ack          = w_grant_rd;
    assign bus.rd_data         = r_rd_data;
    assign bus.rd_valid        = r_rd_valid;
    assign bus.wr_ready        = !w_fifo_full;
    assign bus.wr_level        = w_fifo_level;
    assign bus.sram_read       = r_sram_read;
    assign bus.sram_write      = r_sram_write;
    assign bus.sram_address    = r_sram_address;
    assign bus.sram_data_write = r_sram_data_write;

    // Arbiter FSM with registered strobes: a strobe is set on entry to ISSUE_x and cleared
    // on leaving it, so it is high exactly while the FSM sits in ISSUE_x.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_settle          <= 1'b0;
            r_sram_read       <= 1'b0;
            r_sram_write      <= 1'b0;
            r_sram_address    <= '0;
            r_sram_data_write <= '0;
            r_rd_data         <= '0;
            r_rd_valid        <= 1'b0;
        end else begin
            r_rd_valid   <= 1'b0;
            r_sram_read  <= 1'b0;
            r_sram_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_rd) begin
                        r_sram_address <= bus.rd_addr;
                        r_sram_read    <= 1'b1;
                        r_state        <= ST_ISSUE_RD;
                    end else if (w_grant_wr) begin
                        r_sram_address    <= w_fifo_head.addr;
                        r_sram_data_write <= w_fifo_head.data;
                        r_sram_write      <= 1'b1;
                        r_state           <= ST_ISSUE_WR;
                    end
                end
                ST_ISSUE_RD: begin
                    r_settle <= 1'b1;
                    r_state  <= ST_WAIT_RD;
                end
                ST_ISSUE_WR: begin
                    r_settle <= 1'b1;
                    r_state  <= ST_WAIT_WR;
                end
                // The first WAIT cycle is skipped: the controller still shows the stale
                // ready from before it registered the strobe.
                ST_WAIT_RD: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else if (bus.sram_ready) begin
                        r_rd_data  <= bus.sram_data_read;
                        r_rd_valid <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WAIT_WR: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else if (bus.sram_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read streak: counts reads granted while writes wait; any write grant or an empty
    // FIFO resets it, and it holds at the limit until the forced write goes out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_fifo_empty || w_grant_wr) begin
            r_streak <= '0;
        end else if (w_grant_rd && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: expected SRAM ops and read data are queued by the
// stimulus; a negedge monitor pops and compares on every strobe and rd_valid.
// A small SRAM controller model supplies ready/read data with the controller's timing.
module tb_sram_arbiter;

    logic clk;
    logic reset;

    sram_arbiter_if bus();

    sram_arbiter #(
        .WR_FIFO_DEPTH (4),
        .MAX_RD_STREAK (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [17:0] addr;
        logic [15:0] data;
    } op_t;

    op_t         op_q[$];
    logic [15:0] rd_exp_q[$];
    logic [17:0] rd_addr_q[$];
    int          ack_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Contents of never-written SRAM words
    function automatic logic [15:0] dflt(input logic [17:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_op(input bit w, input logic [17:0] a, input logic [15:0] d);
        op_t o;
        o.is_wr = w;
        o.addr  = a;
        o.data  = d;
        op_q.push_back(o);
    endtask

    task automatic exp_rd(input logic [17:0] a, input logic [15:0] d);
        exp_op(1'b0, a, 16'h0);
        rd_exp_q.push_back(d);
        rd_addr_q.push_back(a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- SRAM controller model ----------------
    // Ready stays high the cycle after the strobe, drops for one cycle, then returns.
    logic        m_p1, m_p2;
    logic [15:0] m_rdata = 16'h0;
    logic [15:0] m_mem [logic [17:0]];

    assign bus.sram_ready     = !m_p2;
    assign bus.sram_data_read = m_rdata;

    always @(posedge clk) begin
        if (reset) begin
            m_p1 <= 1'b0;
            m_p2 <= 1'b0;
        end else begin
            m_p1 <= bus.sram_read | bus.sram_write;
            m_p2 <= m_p1;
        end
        if (bus.sram_read)
            m_rdata <= m_mem.exists(bus.sram_address) ? m_mem[bus.sram_address] : dflt(bus.sram_address);
    end

    always @(posedge clk) begin
        if (bus.sram_write) m_mem[bus.sram_address] = bus.sram_data_write;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- read requester ----------------
    initial begin
        bit took;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        forever begin
            @(negedge clk);
            took = bus.rd_ack && bus.rd_req;
            tick();
            if (took && rd_addr_q.size() > 0) void'(rd_addr_q.pop_front());
            if (rd_addr_q.size() > 0) begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = rd_addr_q[0];
            end else begin
                bus.rd_req  = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            ack_q.delete();
        end else begin
            if (bus.rd_ack) ack_q.push_back(cyc);
            if (bus.sram_read || bus.sram_write) begin
                if (op_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_op: rd=%0b wr=%0b addr=0x%0h, none expected",
                             bus.sram_read, bus.sram_write, bus.sram_address);
                end else begin
                    op_t o;
                    o = op_q.pop_front();
                    chk("op_kind", {30'd0, bus.sram_write, bus.sram_read}, o.is_wr ? 32'd2 : 32'd1);
                    chk("op_addr", {14'd0, bus.sram_address}, {14'd0, o.addr});
                    if (o.is_wr) chk("op_wdata", {16'd0, bus.sram_data_write}, {16'd0, o.data});
                end
            end
            if (bus.rd_valid) begin
                if (rd_exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rd_valid: rd_data=0x%0h, none expected", bus.rd_data);
                end else begin
                    chk("rd_data", {16'd0, bus.rd_data}, {16'd0, rd_exp_q.pop_front()});
                end
                if (ack_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rd_valid_without_ack: got rd_valid, expected a prior rd_ack");
                end else begin
                    chk("rd_latency", cyc - ack_q.pop_front(), 32'd5);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_ack"},     {31'd0, bus.rd_ack}, 32'd0);
        chk({tag, "_rd_valid"},   {31'd0, bus.rd_valid}, 32'd0);
        chk({tag, "_rd_data"},    {16'd0, bus.rd_data}, 32'd0);
        chk({tag, "_sram_read"},  {31'd0, bus.sram_read}, 32'd0);
        chk({tag, "_sram_write"}, {31'd0, bus.sram_write}, 32'd0);
        chk({tag, "_sram_addr"},  {14'd0, bus.sram_address}, 32'd0);
        chk({tag, "_sram_wdata"}, {16'd0, bus.sram_data_write}, 32'd0);
        chk({tag, "_wr_level"},   {29'd0, bus.wr_level}, 32'd0);
        chk({tag, "_wr_ready"},   {31'd0, bus.wr_ready}, 32'd1);
    endtask

    task automatic wait_ack(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = bus.rd_ack;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_ack: no rd_ack within %0d cycles, expected one", max_cyc);
        end
    endtask

    task automatic wait_level0(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = (bus.wr_level == 3'd0);
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_level0: wr_level=%0d after %0d cycles, expected 0", bus.wr_level, max_cyc);
        end
        tick();
    endtask

    task automatic wait_quiet(input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            done = (op_q.size() == 0) && (rd_exp_q.size() == 0) &&
                   (rd_addr_q.size() == 0) && (bus.wr_level == 3'd0);
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL drain: ops=%0d rd_exp=%0d rd_req=%0d level=%0d pending, expected all 0",
                     op_q.size(), rd_exp_q.size(), rd_addr_q.size(), bus.wr_level);
        end
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_vals("reset");
        tick();
        reset = 1'b0;
        tick();

        // Write then read back through the SRAM model
        exp_op(1'b1, 18'h00123, 16'hBEEF);
        bus.wr_valid = 1'b1; bus.wr_addr = 18'h00123; bus.wr_data = 16'hBEEF;
        tick();
        bus.wr_valid = 1'b0;
        wait_level0(50);
        exp_rd(18'h00123, 16'hBEEF);
        wait_quiet(100);

        // Read priority: write waiting while a read is requested in the same IDLE cycle
        exp_rd(18'h01000, dflt(18'h01000));
        exp_rd(18'h01001, dflt(18'h01001));
        exp_op(1'b1, 18'h01800, 16'h3C3C);
        wait_ack(50);
        tick();
        bus.wr_valid = 1'b1; bus.wr_addr = 18'h01800; bus.wr_data = 16'h3C3C;
        tick();
        bus.wr_valid = 1'b0;
        wait_quiet(200);

        // Starvation: one pending write is forced after 8 reads with it waiting
        for (int i = 0; i < 9; i++) exp_rd(18'h02000 + 18'(i), dflt(18'h02000 + 18'(i)));
        exp_op(1'b1, 18'h02800, 16'h1234);
        exp_rd(18'h02009, dflt(18'h02009));
        wait_ack(50);
        tick();
        bus.wr_valid = 1'b1; bus.wr_addr = 18'h02800; bus.wr_data = 16'h1234;
        tick();
        bus.wr_valid = 1'b0;
        wait_quiet(400);
        exp_rd(18'h02800, 16'h1234);
        wait_quiet(100);

        // FIFO full: five back-to-back pushes during continuous reads, fifth dropped
        for (int i = 0; i < 9; i++) exp_rd(18'h03000 + 18'(i), dflt(18'h03000 + 18'(i)));
        for (int i = 0; i < 4; i++) exp_op(1'b1, 18'h03800 + 18'(i), 16'hD000 + 16'(i));
        wait_ack(50);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 18'h03800 + 18'(i);
            bus.wr_data  = 16'hD000 + 16'(i);
            @(negedge clk);
            chk("fill_wr_ready", {31'd0, bus.wr_ready}, (i < 4) ? 32'd1 : 32'd0);
            chk("fill_wr_level", {29'd0, bus.wr_level}, 32'(i));
            tick();
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("full_wr_level", {29'd0, bus.wr_level}, 32'd4);
        tick();
        wait_quiet(600);
        for (int i = 0; i < 4; i++) exp_rd(18'h03800 + 18'(i), 16'hD000 + 16'(i));
        exp_rd(18'h03804, dflt(18'h03804));
        wait_quiet(200);

        // Reset two cycles after rd_ack: read dropped, pending write flushed
        exp_op(1'b0, 18'h04000, 16'h0);
        rd_addr_q.push_back(18'h04000);
        wait_ack(50);
        tick();
        bus.wr_valid = 1'b1; bus.wr_addr = 18'h04800; bus.wr_data = 16'h7777;
        tick();
        bus.wr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("prereset_wr_level", {29'd0, bus.wr_level}, 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midread");
        repeat (15) tick();
        chk("midread_ops_left", 32'(op_q.size()), 32'd0);
        exp_rd(18'h04800, dflt(18'h04800));
        wait_quiet(100);

        // Push/pop in the same cycle at level 1: level holds, older entry leaves first
        exp_op(1'b1, 18'h05000, 16'hA1A1);
        exp_op(1'b1, 18'h05001, 16'hB2B2);
        bus.wr_valid = 1'b1; bus.wr_addr = 18'h05000; bus.wr_data = 16'hA1A1;
        @(negedge clk);
        chk("pp_level_before", {29'd0, bus.wr_level}, 32'd0);
        tick();
        bus.wr_addr = 18'h05001; bus.wr_data = 16'hB2B2;
        @(negedge clk);
        chk("pp_level_one", {29'd0, bus.wr_level}, 32'd1);
        tick();
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("pp_level_hold", {29'd0, bus.wr_level}, 32'd1);
        tick();
        wait_quiet(100);
        exp_rd(18'h05000, 16'hA1A1);
        exp_rd(18'h05001, 16'hB2B2);
        wait_quiet(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller between two requesters: a framebuffer read port (VGA/video fetch, latency-critical) and a pen/pixel write port (buffered).
- Sits directly above the SRAM controller and drives its write/read strobes, address and write data; consumes its ready and read data.
- Reads have priority. Writes are queued in a small FIFO and drained when the read port is idle. A streak limit prevents write starvation.

Parameters:
- WR_FIFO_DEPTH, 4, write FIFO entries; power of 2, at least 2.
- MAX_RD_STREAK, 8, consecutive read grants allowed while the FIFO is non-empty before one write is forced.

Ports:
- clk  in  1  system clock (12 MHz)
- reset  in  1  synchronous, active-high
- rd_req  in  1  read request; held with rd_addr stable until rd_ack
- rd_addr  in  18  read word address
- rd_ack  out  1  one-cycle pulse: read accepted
- rd_data  out  16  read result; valid while rd_valid
- rd_valid  out  1  one-cycle pulse: rd_data valid
- wr_valid  in  1  push write into FIFO
- wr_addr  in  18  write word address
- wr_data  in  16  write data
- wr_ready  out  1  FIFO not full; push accepted only when wr_valid && wr_ready
- wr_level  out  3  FIFO occupancy (0..WR_FIFO_DEPTH)
- sram_write  out  1  write strobe to controller
- sram_read  out  1  read strobe to controller
- sram_address  out  18  address to controller
- sram_data_write  out  16  write data to controller
- sram_data_read  in  16  read data from controller
- sram_ready  in  1  controller idle

Behaviour:
- Reset values: all strobes 0, rd_ack 0, rd_valid 0, rd_data 0, sram_address 0, sram_data_write 0, FIFO empty, wr_level 0, wr_ready 1, streak counter 0, state IDLE.
- State machine: IDLE, ISSUE_RD, ISSUE_WR, WAIT_RD, WAIT_WR.
- IDLE, requires sram_ready=1, grants in this order:
  - If the streak counter equals MAX_RD_STREAK and the FIFO is non-empty, grant write.
  - Else if rd_req, grant read.
  - Else if the FIFO is non-empty, grant write.
  - Else stay in IDLE.
- Read grant (cycle T): rd_ack=1; latch rd_addr into sram_address; go to ISSUE_RD.
- Write grant: pop the FIFO head into sram_address and sram_data_write; go to ISSUE_WR.
- ISSUE_x: matching strobe high for exactly one cycle, then WAIT_x. Strobes are never high outside ISSUE states.
- WAIT_x: ignore the cycle immediately after ISSUE, when the controller has not yet dropped ready. Then wait for sram_ready=1.
  - WAIT_RD: on sram_ready=1, register sram_data_read into rd_data; rd_valid=1 next cycle; go to IDLE.
  - WAIT_WR: on sram_ready=1, go to IDLE.
- Read timing: rd_ack at T, strobe at T+1, data captured at T+4, rd_valid at T+5. The next grant is possible at T+5.
- Streak counter:
  - Increments on each read grant while the FIFO is non-empty.
  - Clears on a write grant or whenever the FIFO is empty.
  - Saturates at MAX_RD_STREAK.
- FIFO behaviour:
  - Push and pop in the same cycle is legal. Pop is evaluated on pre-cycle occupancy.
  - A push when full is dropped; wr_ready=0 prevents it.
  - A push to an empty FIFO is not poppable until the next cycle.
  - Pointers wrap modulo WR_FIFO_DEPTH.
- Only one SRAM operation is outstanding at a time. rd_req is ignored outside IDLE.
- Reset mid-operation: immediate return to IDLE, FIFO flushed, in-flight read dropped (no rd_valid). The controller shares the reset.

Decomposition:
- Shared package `sram_pkg`:
  - SRAM_ADDR_W=18, SRAM_DATA_W=16.
  - Arbiter state encoding constants.
- Sub-module: `sram_wr_fifo`, a synchronous FIFO holding address+data (34 bits).
  - Ports: push, pop, din, dout, full, empty, level.

Test Plan:
- Write then read: push (0x00123, 0xBEEF); when FIFO is empty, rd_req addr 0x00123 -> sram_write pulse with addr 0x00123 / data 0xBEEF, then rd_valid exactly 5 cycles after rd_ack with rd_data=0xBEEF (SRAM model).
- Read priority: FIFO holds 1 write; rd_req asserted in the same IDLE cycle -> read granted first; write issued on the next IDLE.
- Starvation: rd_req held high continuously with 1 FIFO entry, MAX_RD_STREAK=8 -> 8 read grants, then 1 write grant, then reads resume; counter back at 0.
- FIFO full: rd_req held high, push 5 writes back-to-back -> wr_ready low after the 4th, 5th not stored, wr_level=4; all 4 written in order, values verified by readback.
- Reset mid-read: reset asserted at T+2 after rd_ack -> no rd_valid; all outputs return to reset values next cycle; FIFO level 0.
- Simultaneous push/pop at level 1 during a write grant -> level stays 1; the popped entry is the older one.
